// File: rtl/sipo_deser.sv
// sipo_deser: serial-in, parallel-out deserializer with a holding register.
// Bits arrive MSB first, qualified by in_valid. A completed frame moves
// into the holding register ('out') under a valid/ready handshake. If the
// holding register is still occupied, the frame is dropped and 'overrun'
// is set; 'overrun' stays set until 'sync' clears it.
// 'sync' realigns frame boundaries by clearing the bit counter.
// Optional feature macro: SIPO_PARITY_EN adds one even-parity bit per frame
// and a registered parity_err flag that travels with 'out'.
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             in_valid,
  input  logic             din,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err,
  output logic             busy
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  // The last bit of a frame is consumed straight from din on the completing
  // edge, so the shift register only has to hold the first FRAME-1 bits.
  localparam int SREG_W = FRAME - 1;
  localparam int CNT_W  = (FRAME > 2) ? $clog2(FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  logic [SREG_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic              busy_q, busy_d;
  logic              take;
  logic              complete;
  logic [WIDTH-1:0]  word;

`ifdef SIPO_PARITY_EN
  logic              perr_q, perr_d;

  // Even parity over data bits plus the received parity bit; 1 means error.
  function automatic logic parity_check(input logic [WIDTH-1:0] data,
                                        input logic pbit);
    return (^data) ^ pbit;
  endfunction

  // With parity, the shift register holds exactly the data bits and din
  // carries the parity bit when the frame completes.
  assign word = sreg_q;
`else
  // Without parity, din is the final (LSB) data bit.
  assign word = {sreg_q, din};
`endif

  assign take     = out_valid_q & out_ready;
  assign complete = in_valid & ~sync & (cnt_q == LAST);

  // Next-state logic for the shift stage, the holding register and flags.
  always_comb begin
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
`ifdef SIPO_PARITY_EN
    perr_d      = perr_q;
`endif

    // A take empties the holding register unless a completion refills it.
    if (take) begin
      out_valid_d = 1'b0;
    end

    if (sync) begin
      // Resync drops any partial frame and the bit sampled this cycle.
      cnt_d     = '0;
      sreg_d    = '0;
      overrun_d = 1'b0;
    end else if (in_valid) begin
      sreg_d = SREG_W'({sreg_q, din});
      if (complete) begin
        cnt_d = '0;
        if (!out_valid_q || take) begin
          out_d       = word;
          out_valid_d = 1'b1;
`ifdef SIPO_PARITY_EN
          perr_d      = parity_check(sreg_q, din);
`endif
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    busy_d = (cnt_d != '0);
  end

  // State registers; reset clears everything, including the data word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q      <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

`ifdef SIPO_PARITY_EN
  // Parity flag is captured together with the word it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed testbench for sipo_deser (WIDTH = 4). Works with or without
// SIPO_PARITY_EN; the parity scenario is only exercised when it is defined.
module tb_sipo_deser;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             sync;
  logic             in_valid;
  logic             din;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;
  logic             parity_err;
  logic             busy;

  int vec;
  int miss;

  sipo_deser #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sync      (sync),
    .in_valid  (in_valid),
    .din       (din),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
    .parity_err(parity_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic apply(input logic v, input logic d, input logic r, input logic s);
    in_valid  = v;
    din       = d;
    out_ready = r;
    sync      = s;
    @(posedge clk);
    #1;
  endtask

  // Send one frame MSB first; the parity bit is appended only when enabled.
  // rb is out_ready during all but the final bit, rl during the final bit.
  task automatic send_frame(input logic [3:0] w, input logic p,
                            input logic rb, input logic rl);
`ifdef SIPO_PARITY_EN
    for (int i = 3; i >= 0; i--) apply(1'b1, w[i], rb, 1'b0);
    apply(1'b1, p, rl, 1'b0);
`else
    for (int i = 3; i >= 1; i--) apply(1'b1, w[i], rb, 1'b0);
    apply(1'b1, w[0], rl, 1'b0);
    if (p) begin end
`endif
  endtask

  task automatic drain();
    apply(1'b0, 1'b0, 1'b1, 1'b0);
    vec++;
    if (out_valid !== 1'b0) begin
      $display("FAIL drain_valid got %0b exp 0", out_valid); miss++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sync = 1'b0; in_valid = 1'b0; din = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    vec++; if (out !== 4'h0) begin $display("FAIL reset_out got %h exp 0", out); miss++; end
    vec++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid got %0b exp 0", out_valid); miss++; end
    vec++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun got %0b exp 0", overrun); miss++; end
    vec++; if (parity_err !== 1'b0) begin $display("FAIL reset_perr got %0b exp 0", parity_err); miss++; end
    vec++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %0b exp 0", busy); miss++; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_frame();
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    vec++; if (busy !== 1'b1) begin $display("FAIL single_busy_mid got %0b exp 1", busy); miss++; end
    vec++; if (out_valid !== 1'b0) begin $display("FAIL single_valid_early got %0b exp 0", out_valid); miss++; end
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    vec++; if (out_valid !== 1'b0) begin $display("FAIL single_valid_prepar got %0b exp 0", out_valid); miss++; end
`endif
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    vec++; if (out !== 4'b1010) begin $display("FAIL single_out got %h exp a", out); miss++; end
    vec++; if (out_valid !== 1'b1) begin $display("FAIL single_valid got %0b exp 1", out_valid); miss++; end
    vec++; if (busy !== 1'b0) begin $display("FAIL single_busy_end got %0b exp 0", busy); miss++; end
    vec++; if (overrun !== 1'b0) begin $display("FAIL single_overrun got %0b exp 0", overrun); miss++; end
    vec++; if (parity_err !== 1'b0) begin $display("FAIL single_perr got %0b exp 0", parity_err); miss++; end
    // Idle cycle with out_ready low: word must be held.
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    vec++; if (out !== 4'b1010 || out_valid !== 1'b1) begin
      $display("FAIL single_hold got %h/%0b exp a/1", out, out_valid); miss++;
    end
    drain();
  endtask

  task automatic test_back_to_back();
    send_frame(4'b1100, 1'b0, 1'b1, 1'b1);
    vec++; if (out !== 4'b1100 || out_valid !== 1'b1) begin
      $display("FAIL b2b_first got %h/%0b exp c/1", out, out_valid); miss++;
    end
    send_frame(4'b0111, 1'b1, 1'b1, 1'b1);
    vec++; if (out !== 4'b0111 || out_valid !== 1'b1) begin
      $display("FAIL b2b_second got %h/%0b exp 7/1", out, out_valid); miss++;
    end
    vec++; if (overrun !== 1'b0) begin $display("FAIL b2b_overrun got %0b exp 0", overrun); miss++; end
    drain();
  endtask

  task automatic test_take_complete();
    send_frame(4'b1001, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0, 1'b1);
    vec++; if (out !== 4'b0110) begin $display("FAIL takecmp_out got %h exp 6", out); miss++; end
    vec++; if (out_valid !== 1'b1) begin $display("FAIL takecmp_valid got %0b exp 1", out_valid); miss++; end
    vec++; if (overrun !== 1'b0) begin $display("FAIL takecmp_overrun got %0b exp 0", overrun); miss++; end
    drain();
  endtask

  task automatic test_overrun();
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0);
    send_frame(4'b0101, 1'b0, 1'b0, 1'b0);
    vec++; if (out !== 4'b1010) begin $display("FAIL ovr_out got %h exp a", out); miss++; end
    vec++; if (overrun !== 1'b1) begin $display("FAIL ovr_flag got %0b exp 1", overrun); miss++; end
    vec++; if (out_valid !== 1'b1) begin $display("FAIL ovr_valid got %0b exp 1", out_valid); miss++; end
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    vec++; if (overrun !== 1'b1) begin $display("FAIL ovr_sticky got %0b exp 1", overrun); miss++; end
    apply(1'b0, 1'b0, 1'b0, 1'b1);
    vec++; if (overrun !== 1'b0) begin $display("FAIL ovr_sync_clr got %0b exp 0", overrun); miss++; end
    vec++; if (out_valid !== 1'b1 || out !== 4'b1010) begin
      $display("FAIL ovr_sync_keep got %h/%0b exp a/1", out, out_valid); miss++;
    end
    drain();
  endtask

  task automatic test_gaps_resync();
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 1'b0);
`endif
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    vec++; if (out !== 4'b1010 || out_valid !== 1'b1) begin
      $display("FAIL gaps_out got %h/%0b exp a/1", out, out_valid); miss++;
    end
    drain();
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    // Sync with a valid bit present: the bit is dropped and the count cleared.
    apply(1'b1, 1'b1, 1'b0, 1'b1);
    vec++; if (busy !== 1'b0) begin $display("FAIL resync_busy got %0b exp 0", busy); miss++; end
    send_frame(4'b0011, 1'b0, 1'b0, 1'b0);
    vec++; if (out !== 4'b0011 || out_valid !== 1'b1) begin
      $display("FAIL resync_out got %h/%0b exp 3/1", out, out_valid); miss++;
    end
    drain();
  endtask

  task automatic test_async_reset();
    send_frame(4'b1111, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3 rst = 1'b1;
    #1;
    vec++; if (out !== 4'h0 || out_valid !== 1'b0 || overrun !== 1'b0 ||
               parity_err !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL arst_outputs got %h/%0b/%0b/%0b/%0b exp 0/0/0/0/0",
               out, out_valid, overrun, parity_err, busy); miss++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(4'b0110, 1'b0, 1'b0, 1'b0);
    vec++; if (out !== 4'b0110 || out_valid !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL arst_newframe got %h/%0b/%0b exp 6/1/0", out, out_valid, busy); miss++;
    end
    drain();
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    send_frame(4'b1010, 1'b0, 1'b0, 1'b0);
    vec++; if (out !== 4'b1010 || parity_err !== 1'b0) begin
      $display("FAIL par_ok got %h/%0b exp a/0", out, parity_err); miss++;
    end
    drain();
    send_frame(4'b1011, 1'b0, 1'b0, 1'b0);
    vec++; if (out !== 4'b1011 || parity_err !== 1'b1 || out_valid !== 1'b1) begin
      $display("FAIL par_err got %h/%0b/%0b exp b/1/1", out, parity_err, out_valid); miss++;
    end
    drain();
  endtask
`endif

  initial begin
    vec  = 0;
    miss = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_take_complete();
    test_overrun();
    test_gaps_resync();
    test_async_reset();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
